// File: rtl/bcd_display_pkg.sv
// Shared constants and helpers for the BCD timer and its 7-segment scan.
// Segment patterns are active-low and packed as {g,f,e,d,c,b,a}.
package bcd_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40,
    7'h79,
    7'h24,
    7'h30,
    7'h19,
    7'h12,
    7'h02,
    7'h78,
    7'h00,
    7'h10
  };

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] digit
  );
    if (digit > BCD_MAX) begin
      return SEG_BLANK;
    end
    return SEG_DIGIT[int'(digit)];
  endfunction

  // Out-of-range nibbles saturate to 9 so the
  // counter never holds a non-BCD digit.
  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] digit
  );
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade: load, increment/decrement with carry/borrow chaining.
// Ports: i_clk, i_reset, i_load, i_load_digit, i_tick, i_up,
//        i_carry_in, o_digit (registered), o_carry_out (combinational).
module bcd_decade
  import bcd_display_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [3:0] i_load_digit,
  input  logic       i_tick,
  input  logic       i_up,
  input  logic       i_carry_in,
  output logic [3:0] o_digit,
  output logic       o_carry_out
);

  logic [3:0] r_digit;
  logic       w_at_edge;
  logic       w_step;

  // At the wrap boundary for the current direction:
  // 9 when counting up, 0 when counting down.
  assign w_at_edge = i_up ? (r_digit == BCD_MAX)
                          : (r_digit == 4'd0);

  // A decade only moves when every lower decade
  // is also wrapping, i.e. the carry ripples in.
  assign w_step      = i_tick & i_carry_in;
  assign o_carry_out = i_carry_in & w_at_edge;
  assign o_digit     = r_digit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= bcd_clamp(i_load_digit);
    end else if (w_step) begin
      if (i_up) begin
        r_digit <= w_at_edge ? 4'd0
                             : r_digit + 4'd1;
      end else begin
        r_digit <= w_at_edge ? BCD_MAX
                             : r_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// N-digit BCD up/down timer with tick prescaler and 7-seg scan driver.
// Ports: clk_100MHz, reset (sync, high), enable, up, load, load_value,
//        count, tc, display_anodes (active-low), display_cathodes
//        (active-low {g..a}). Optional: LEADING_ZERO_BLANK_EN blanks
//        leading zero digits on the display (digit 0 never blanked).
module bcd_updown_timer
  import bcd_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 200_000
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                enable,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic [7:0]          display_anodes,
  output logic [6:0]          display_cathodes
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] PRE_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]       r_pre;
  logic                w_pre_wrap;
  logic                w_tick;

  logic [SW-1:0]       r_sdiv;
  logic                w_scan_wrap;
  logic [IW-1:0]       r_idx;

  logic [DIGITS:0]     w_carry;
  logic [4*DIGITS-1:0] w_count;
  logic                r_tc;

  logic [DIGITS-1:0]   w_lz;
  logic [3:0]          w_sel;
  logic                w_sel_lz;
  logic [6:0]          w_seg;
  logic [7:0]          w_an;

  logic [7:0]          r_an;
  logic [6:0]          r_ca;

  // Prescaler holds its phase while disabled,
  // so resuming keeps the original tick spacing.
  assign w_pre_wrap = (r_pre == PRE_LAST);
  assign w_tick     = enable & w_pre_wrap;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_pre <= '0;
    end else if (enable) begin
      r_pre <= w_pre_wrap ? '0
                          : r_pre + TW'(1);
    end
  end

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_decade u_dec (
      .i_clk        (clk_100MHz),
      .i_reset      (reset),
      .i_load       (load),
      .i_load_digit (load_value[4*g +: 4]),
      .i_tick       (w_tick),
      .i_up         (up),
      .i_carry_in   (w_carry[g]),
      .o_digit      (w_count[4*g +: 4]),
      .o_carry_out  (w_carry[g+1])
    );
  end

  // A carry out of the top decade on a tick means
  // the whole counter wrapped this edge.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_tc <= 1'b0;
    end else if (load) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= w_tick & w_carry[DIGITS];
    end
  end

  assign count = w_count;
  assign tc    = r_tc;

  assign w_scan_wrap = (r_sdiv == SCAN_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_sdiv <= '0;
      r_idx  <= '0;
    end else begin
      r_sdiv <= w_scan_wrap ? '0
                            : r_sdiv + SW'(1);
      if (w_scan_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? '0
                                     : r_idx + IW'(1);
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top decade; a digit is a
  // leading zero while everything above it is 0.
  always_comb begin
    logic v_run;
    w_lz  = '0;
    v_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_run   = v_run & (w_count[4*i +: 4] == 4'd0);
      w_lz[i] = v_run;
    end
  end
`else
  assign w_lz = '0;
`endif

  always_comb begin
    w_sel    = 4'd0;
    w_sel_lz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(r_idx) == i) begin
        w_sel    = w_count[4*i +: 4];
        w_sel_lz = w_lz[i];
      end
    end
  end

  assign w_seg = w_sel_lz ? SEG_BLANK
                          : bcd_to_seg(w_sel);

  always_comb begin
    w_an = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (i < DIGITS && int'(r_idx) == i) begin
        w_an[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_an <= 8'hFF;
      r_ca <= SEG_BLANK;
    end else begin
      r_an <= w_an;
      r_ca <= w_seg;
    end
  end

  assign display_anodes   = r_an;
  assign display_cathodes = r_ca;

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Randomized scoreboard bench for bcd_updown_timer.
// Reference model works on the integer count value, not on BCD digits.
module tb_bcd_updown_timer;

  localparam int DIG  = 4;
  localparam int TDIV = 4;
  localparam int SDIV = 2;
  localparam int MAXV = 9999;

  logic            clk;
  logic            reset;
  logic            enable;
  logic            up;
  logic            load;
  logic [15:0]     load_value;
  logic [15:0]     count;
  logic            tc;
  logic [7:0]      display_anodes;
  logic [6:0]      display_cathodes;

  typedef struct packed {
    logic [15:0] cnt;
    logic        tc;
    logic [7:0]  an;
    logic [6:0]  ca;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;

  int m_val, m_pre, m_sdiv, m_idx;
  logic       m_tc;
  logic [7:0] m_an;
  logic [6:0] m_ca;

  bcd_updown_timer #(
    .DIGITS   (DIG),
    .TICK_DIV (TDIV),
    .SCAN_DIV (SDIV)
  ) dut (
    .clk_100MHz       (clk),
    .reset            (reset),
    .enable           (enable),
    .up               (up),
    .load             (load),
    .load_value       (load_value),
    .count            (count),
    .tc               (tc),
    .display_anodes   (display_anodes),
    .display_cathodes (display_cathodes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clamp_val(input logic [15:0] lv);
    int v = 0;
    int n;
    for (int i = 0; i < DIG; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * pow10(i);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b = '0;
    for (int i = 0; i < DIG; i++) begin
      b[4*i +: 4] = 4'((v / pow10(i)) % 10);
    end
    return b;
  endfunction

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: one expectation per clock edge.
  always @(posedge clk) begin : model
    int  d;
    logic tk;
    if (reset) begin
      m_val  = 0;
      m_tc   = 1'b0;
      m_pre  = 0;
      m_sdiv = 0;
      m_idx  = 0;
      m_an   = 8'hFF;
      m_ca   = 7'h7F;
    end else begin
      d = (m_val / pow10(m_idx)) % 10;
      m_an = 8'hFF;
      m_an[m_idx] = 1'b0;
      m_ca = seg_ref(d);
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && m_val < pow10(m_idx)) m_ca = 7'h7F;
`endif
      tk = enable && (m_pre == TDIV - 1);
      if (enable) m_pre = (m_pre + 1) % TDIV;
      m_tc = 1'b0;
      if (load) begin
        m_val = clamp_val(load_value);
      end else if (tk) begin
        if (up) begin
          m_tc  = (m_val == MAXV);
          m_val = (m_val + 1) % (MAXV + 1);
        end else begin
          m_tc  = (m_val == 0);
          m_val = (m_val + MAXV) % (MAXV + 1);
        end
      end
      if (m_sdiv == SDIV - 1) begin
        m_sdiv = 0;
        m_idx  = (m_idx + 1) % DIG;
      end else begin
        m_sdiv = m_sdiv + 1;
      end
    end
    q.push_back('{to_bcd(m_val), m_tc, m_an, m_ca});
  end

  // Monitor: compare DUT outputs against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count",    32'(count),            32'(e.cnt));
      chk("tc",       32'(tc),               32'(e.tc));
      chk("anodes",   32'(display_anodes),   32'(e.an));
      chk("cathodes", 32'(display_cathodes), 32'(e.ca));
    end
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    up         = 1'b1;
    load       = 1'b0;
    load_value = '0;
    repeat (3) @(negedge clk);

    reset  = 1'b0;
    enable = 1'b1;
    up     = 1'b1;
    repeat (40) @(negedge clk);
    chk("ten_ticks", 32'(count), 32'h0010);
    enable = 1'b0;

    load = 1'b1; load_value = 16'h9998;
    @(negedge clk);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    repeat (10) @(negedge clk);

    enable = 1'b0;
    load = 1'b1; load_value = 16'h0000;
    @(negedge clk);
    load = 1'b0; up = 1'b0; enable = 1'b1;
    repeat (10) @(negedge clk);

    enable = 1'b0;
    load = 1'b1; load_value = 16'h0A5F;
    @(negedge clk);
    load = 1'b0;
    chk("clamp", 32'(count), 32'h0959);

    enable = 1'b1; up = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b1; load_value = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    chk("load_beats_tick", 32'(count), 32'h1234);
    chk("load_tc", 32'(tc), 32'h0);

    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold", 32'(count), 32'h1234);
    enable = 1'b1;
    @(negedge clk);
    chk("resume_phase", 32'(count), 32'h1234);
    @(negedge clk);
    chk("resume_tick", 32'(count), 32'h1235);

    enable = 1'b0;
    load = 1'b1; load_value = 16'h0042;
    @(negedge clk);
    load = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_anodes", 32'(display_anodes), 32'hFF);
    reset = 1'b0;

    repeat (3000) begin
      enable = ($urandom_range(0, 9) != 0);
      up     = 1'($urandom_range(0, 1));
      load   = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 2))
        0: load_value = 16'($urandom);
        1: load_value = 16'h9997;
        default: load_value = 16'h0002;
      endcase
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end

    reset = 1'b0; load = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
